// File: rtl/param_sync_fifo_pkg.sv
// ---------------------------------------------------------------------------
// param_sync_fifo_pkg
// Shared helpers for the video-debug FIFO slice:
//   addr_width() : RAM address width derived from an entry count
//   DOUT_RST_BIT : reset value replicated across the dout register
// ---------------------------------------------------------------------------
package param_sync_fifo_pkg;

    // Address width for a RAM of 'depth' entries (never below 1 bit).
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam logic DOUT_RST_BIT = 1'b0;

endpackage

// File: rtl/param_sync_fifo_if.sv
// ---------------------------------------------------------------------------
// param_sync_fifo_if
// Handshake/status bundle for param_sync_fifo.
//   master : producer/consumer side (drives din, we, oe, err_clr)
//   slave  : FIFO side (drives dout, dout_valid, flags, count, errors)
// ---------------------------------------------------------------------------
interface param_sync_fifo_if #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 1024
);
    import param_sync_fifo_pkg::*;

    localparam int CW = addr_width(FIFO_DEPTH) + 1;

    logic [DATA_WIDTH-1:0] din;
    logic                  we;
    logic [DATA_WIDTH-1:0] dout;
    logic                  oe;
    logic                  dout_valid;
    logic                  err_clr;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [CW-1:0]         count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output din, we, oe, err_clr,
        input  dout, dout_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  din, we, oe, err_clr,
        output dout, dout_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

endinterface

// File: rtl/param_sync_fifo_ram.sv
// ---------------------------------------------------------------------------
// param_sync_fifo_ram
// Simple dual-port RAM, one write port, one registered read port.
// Read data appears after the edge on which re is sampled high and holds
// until the next read. Contents are not reset.
//   clk          : clock
//   we/waddr/wdata : write port
//   re/raddr     : read request/address
//   rdata        : registered read data
// ---------------------------------------------------------------------------
module param_sync_fifo_ram
    import param_sync_fifo_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int RAM_DEPTH  = 1024,
    localparam int AW         = addr_width(RAM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/param_sync_fifo.sv
// ---------------------------------------------------------------------------
// param_sync_fifo
// Single-clock FIFO with occupancy count, almost-full/empty thresholds and
// sticky overflow/underflow flags.
//   clk  : clock, rising edge
//   rst  : synchronous, active-high reset
//   bus  : param_sync_fifo_if.slave (din/we, dout/oe/dout_valid, err_clr,
//          full/empty/almost_*, count, overflow/underflow)
// Build option: PARAM_SYNC_FIFO_FWFT_EN adds a prefetch output stage so the
// head word is presented on dout without a request (first-word-fall-through).
// ---------------------------------------------------------------------------
module param_sync_fifo
    import param_sync_fifo_pkg::*;
#(
    parameter  int DATA_WIDTH    = 32,
    parameter  int FIFO_DEPTH    = 1024,
    parameter  int AFULL_THRESH  = FIFO_DEPTH - 4,
    parameter  int AEMPTY_THRESH = 4,
    localparam int AW            = addr_width(FIFO_DEPTH),
    localparam int CW            = AW + 1
) (
    input  logic clk,
    input  logic rst,
    param_sync_fifo_if.slave bus
);

    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AFULL_THRESH);
    localparam logic [CW-1:0] AE_C    = CW'(AEMPTY_THRESH);

    logic [AW:0]           wr_ptr, rd_ptr;
    logic [CW-1:0]         count_q;
    logic                  ptr_empty;
    logic                  full_o, empty_o;
    logic                  wr_acc;     // write lands in RAM
    logic                  pop;        // user-visible read accepted
    logic                  fetch;      // RAM read issued
    logic                  rd_err;     // read attempted with nothing to give
    logic                  ovf_q, udf_q;
    logic [DATA_WIDTH-1:0] ram_q;
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  dout_vld;

    assign ptr_empty = (wr_ptr == rd_ptr);

`ifdef PARAM_SYNC_FIFO_FWFT_EN
    logic rd_pend;    // RAM read data register holds a fetched word
    logic dout_load;  // fetched word moves into the output register

    // count covers RAM + fetched + presented words, so capacity tracks count.
    assign full_o    = (count_q == DEPTH_C);
    assign empty_o   = !dout_vld;
    assign pop       = bus.oe && dout_vld;
    assign rd_err    = bus.oe && !dout_vld;
    assign dout_load = rd_pend && (!dout_vld || pop);
    // Refill the RAM read register whenever it will be free next cycle;
    // keeps one word queued behind dout so pops can run every cycle.
    assign fetch     = !ptr_empty && (!rd_pend || dout_load);

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pend  <= 1'b0;
            dout_vld <= 1'b0;
            dout_q   <= {DATA_WIDTH{DOUT_RST_BIT}};
        end else begin
            rd_pend <= fetch || (rd_pend && !dout_load);
            if (dout_load) begin
                dout_vld <= 1'b1;
                dout_q   <= ram_q;
            end else if (pop) begin
                dout_vld <= 1'b0;
            end
        end
    end
`else
    logic       ptr_full;
    logic [1:0] vld_pipe;  // [0]: RAM read in flight, [1]: dout just loaded

    // Same low bits, different wrap bit: every entry is in use.
    assign ptr_full = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign full_o   = ptr_full;
    assign empty_o  = ptr_empty;
    assign pop      = bus.oe && !ptr_empty;
    assign rd_err   = bus.oe && ptr_empty;
    assign fetch    = pop;
    assign dout_vld = vld_pipe[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            dout_q   <= {DATA_WIDTH{DOUT_RST_BIT}};
        end else begin
            vld_pipe <= {vld_pipe[0], fetch};
            if (vld_pipe[0]) dout_q <= ram_q;
        end
    end
`endif

    assign wr_acc = bus.we && !full_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (fetch)  rd_ptr <= rd_ptr + 1'b1;
            case ({wr_acc, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Sticky errors: a new event wins over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            if (bus.we && full_o)  ovf_q <= 1'b1;
            else if (bus.err_clr)  ovf_q <= 1'b0;
            if (rd_err)            udf_q <= 1'b1;
            else if (bus.err_clr)  udf_q <= 1'b0;
        end
    end

    param_sync_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .RAM_DEPTH  (FIFO_DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (bus.din),
        .re    (fetch),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (ram_q)
    );

    assign bus.dout         = dout_q;
    assign bus.dout_valid   = dout_vld;
    assign bus.full         = full_o;
    assign bus.empty        = empty_o;
    assign bus.almost_full  = (count_q >= AF_C);
    assign bus.almost_empty = (count_q <= AE_C);
    assign bus.count        = count_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = udf_q;

endmodule

// File: tb/tb_param_sync_fifo.sv
// ---------------------------------------------------------------------------
// tb_param_sync_fifo
// Drives param_sync_fifo (DEPTH=16, AFULL=12, AEMPTY=2, 8-bit data) with
// directed sequences and random traffic, and compares every cycle against a
// queue-based model of the FIFO contract.
// ---------------------------------------------------------------------------
module tb_param_sync_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AF    = 12;
    localparam int AE    = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    param_sync_fifo_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) bus ();

    param_sync_fifo #(
        .DATA_WIDTH    (DW),
        .FIFO_DEPTH    (DEPTH),
        .AFULL_THRESH  (AF),
        .AEMPTY_THRESH (AE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---- reference model -------------------------------------------------
    typedef struct {
        logic [DW-1:0] d;
        int            stamp;   // edge on which the word was written
    } ent_t;

    ent_t          q[$];
    int            edge_idx = 0;
    logic          exp_ovf  = 1'b0;
    logic          exp_udf  = 1'b0;
    logic [DW-1:0] exp_dout = '0;
    logic          exp_dv   = 1'b0;
    logic          pend_v   = 1'b0;
    logic [DW-1:0] pend_d   = '0;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @edge %0d: got %0h expected %0h", tag, edge_idx, got, exp);
        end
    endtask

    // Head word is presented once it has been stored for two edges (FWFT),
    // or any stored word may be requested (standard mode).
    function automatic logic head_visible();
`ifdef PARAM_SYNC_FIFO_FWFT_EN
        return (q.size() > 0) && (q[0].stamp + 2 <= edge_idx);
`else
        return q.size() > 0;
`endif
    endfunction

    // One clock: apply inputs, advance model across the edge, check outputs.
    task automatic cycle(input logic w, input logic [DW-1:0] d, input logic r,
                         input logic ec, input logic rs);
        logic full_m, vis, wa, ra;
        ent_t e;
        bus.we      = w;
        bus.din     = d;
        bus.oe      = r;
        bus.err_clr = ec;
        rst         = rs;
        full_m      = (q.size() == DEPTH);
        vis         = head_visible();
        @(posedge clk);
        edge_idx++;
        if (rs) begin
            q.delete();
            exp_ovf  = 1'b0;
            exp_udf  = 1'b0;
            exp_dout = '0;
            exp_dv   = 1'b0;
            pend_v   = 1'b0;
        end else begin
            wa = w && !full_m;
            ra = r && vis;
            if (w && full_m) exp_ovf = 1'b1;
            else if (ec)     exp_ovf = 1'b0;
            if (r && !vis)   exp_udf = 1'b1;
            else if (ec)     exp_udf = 1'b0;
`ifdef PARAM_SYNC_FIFO_FWFT_EN
            if (ra) void'(q.pop_front());
            e.d = d; e.stamp = edge_idx;
            if (wa) q.push_back(e);
            exp_dv = head_visible();
            if (exp_dv) exp_dout = q[0].d;
`else
            exp_dv = pend_v;
            if (pend_v) exp_dout = pend_d;
            pend_v = ra;
            if (ra) begin
                pend_d = q[0].d;
                void'(q.pop_front());
            end
            e.d = d; e.stamp = edge_idx;
            if (wa) q.push_back(e);
`endif
        end
        #1;
        chk("count",        32'(bus.count),        32'(q.size()));
        chk("full",         32'(bus.full),         32'(q.size() == DEPTH));
`ifdef PARAM_SYNC_FIFO_FWFT_EN
        chk("empty",        32'(bus.empty),        32'(!exp_dv));
`else
        chk("empty",        32'(bus.empty),        32'(q.size() == 0));
`endif
        chk("almost_full",  32'(bus.almost_full),  32'(q.size() >= AF));
        chk("almost_empty", 32'(bus.almost_empty), 32'(q.size() <= AE));
        chk("overflow",     32'(bus.overflow),     32'(exp_ovf));
        chk("underflow",    32'(bus.underflow),    32'(exp_udf));
        chk("dout_valid",   32'(bus.dout_valid),   32'(exp_dv));
`ifdef PARAM_SYNC_FIFO_FWFT_EN
        if (exp_dv || rs) chk("dout", 32'(bus.dout), 32'(exp_dout));
`else
        chk("dout", 32'(bus.dout), 32'(exp_dout));
`endif
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        bus.we = 1'b0; bus.din = '0; bus.oe = 1'b0; bus.err_clr = 1'b0;

        // Reset state
        do_reset();

        // Fill to full, then one write too many
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, DW'(i), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);

        // Drain in order, then read from empty and clear the flag
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        idle(3);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        idle(1);
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);

        // Write + read while full; then overflow set vs clear same cycle
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, DW'(8'h40 + i), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 8'h50, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'h51, 1'b0, 1'b1, 1'b0);
        idle(2);

        // Empty + write + read same cycle
        do_reset();
        cycle(1'b1, 8'h33, 1'b1, 1'b0, 1'b0);
        idle(3);

        // Wrap: interleaved write/read over three depths
        do_reset();
        for (int i = 0; i < 3 * DEPTH; i++) begin
            cycle(1'b1, DW'(i * 7 + 1), 1'b0, 1'b0, 1'b0);
            cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        end
        idle(3);

        // Single word into empty FIFO with oe low, then mid-stream reset
        do_reset();
        cycle(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
        idle(3);
        cycle(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'h22, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
        idle(2);

        // Random traffic in phases of differing write/read pressure
        for (int ph = 0; ph < 6; ph++) begin
            int wp, rp;
            wp = (ph % 3 == 0) ? 80 : (ph % 3 == 1) ? 30 : 55;
            rp = (ph % 3 == 0) ? 30 : (ph % 3 == 1) ? 80 : 55;
            for (int i = 0; i < 150; i++) begin
                cycle(($urandom_range(99) < wp), DW'($urandom),
                      ($urandom_range(99) < rp), ($urandom_range(15) == 0),
                      ($urandom_range(299) == 0));
            end
        end
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
